// File: rtl/sa_row_serializer_if.sv
// sa_row_serializer_if: row-input and FIFO-write signal bundle for sa_row_serializer.
//   in_valid   row available on in_data (from producer)
//   in_ready   row accepted when in_valid && in_ready (from serializer, combinational)
//   in_data    NUM_COL words; column c at [c*DATA_W +: DATA_W]
//   fifo_full  FIFO cannot take a write this cycle
//   fifo_wr_en FIFO write strobe (from serializer, combinational)
//   fifo_addr  address tag of the current word
//   fifo_data  current word
// master: the serializer side. slave: producer/FIFO side.
interface sa_row_serializer_if #(
  parameter int unsigned NUM_COL = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_COL*DATA_W-1:0]   in_data;
  logic                        fifo_full;
  logic                        fifo_wr_en;
  logic [ADDR_W-1:0]           fifo_addr;
  logic [DATA_W-1:0]           fifo_data;

  modport master (
    input  in_valid, in_data, fifo_full,
    output in_ready, fifo_wr_en, fifo_addr, fifo_data
  );

  modport slave (
    output in_valid, in_data, fifo_full,
    input  in_ready, fifo_wr_en, fifo_addr, fifo_data
  );
endinterface

// File: rtl/sa_row_serializer.sv
// sa_row_serializer: captures one systolic-array row (NUM_COL words) and
// writes it to the output FIFO one word per cycle, tagging each word with an
// incrementing address. Stalls on fifo_full without dropping words.
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous reset, active-high
//   start      pulse: load base_addr into the address counter, clear row_cnt
//   base_addr  address of column 0 of the first row after start
//   bus        sa_row_serializer_if.master (row input handshake + FIFO write side)
//   busy       a row is being serialized
//   row_cnt    rows fully written since start/reset (wraps at 2**16)
module sa_row_serializer #(
  parameter int unsigned NUM_COL = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  sa_row_serializer_if.master    bus,
  output logic                   busy,
  output logic [15:0]            row_cnt
);

  localparam int unsigned CIDX_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   row_buf [NUM_COL];
  logic [CIDX_W-1:0]   col_idx;
  logic [ADDR_W-1:0]   row_addr;
  logic [ADDR_W-1:0]   cur_addr;
  logic                in_ready_c;
  logic                wr_en_c;
  logic                accept;
  logic                take;
  logic                last_col;

  assign last_col = (col_idx == CIDX_W'(NUM_COL - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake strobes; start in IDLE blocks acceptance that cycle
  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    wr_en_c    = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = !start;
        accept     = bus.in_valid && !start;
        if (accept) state_next = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        wr_en_c = !bus.fifo_full;
        take    = !bus.fifo_full;
        if (take && last_col) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row buffer, column index, address counters and completed-row count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(NUM_COL); c++) row_buf[c] <= '0;
      col_idx  <= '0;
      row_addr <= '0;
      cur_addr <= '0;
      row_cnt  <= '0;
    end else begin
      if (state == IDLE && start) begin
        cur_addr <= base_addr;
        row_cnt  <= '0;
      end
      if (accept) begin
        for (int c = 0; c < int'(NUM_COL); c++)
          row_buf[c] <= bus.in_data[c*DATA_W +: DATA_W];
        row_addr <= cur_addr;
        cur_addr <= cur_addr + ADDR_W'(NUM_COL);
        col_idx  <= '0;
      end
      if (take) begin
        if (last_col) begin
          col_idx <= '0;
          row_cnt <= row_cnt + CNT_W'(1);
        end else begin
          col_idx <= col_idx + CIDX_W'(1);
        end
      end
    end
  end

  // Word view is held while stalled because col_idx only advances on a taken write
  assign bus.in_ready   = in_ready_c;
  assign bus.fifo_wr_en = wr_en_c;
  assign bus.fifo_data  = row_buf[col_idx];
  assign bus.fifo_addr  = row_addr + ADDR_W'(col_idx);

endmodule

// File: tb/tb_sa_row_serializer.sv
// tb_sa_row_serializer: table-driven row vectors, hand-written multi-cycle
// sequences (reset mid-row, back-to-back rows, backpressure, start+valid
// collision) and a randomized phase, all watched by a queue-based model of
// the expected FIFO write stream.
module tb_sa_row_serializer;
  localparam int unsigned NUM_COL = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        busy;
  logic [15:0] row_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wcyc[$];

  sa_row_serializer_if #(.NUM_COL(NUM_COL), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  sa_row_serializer #(.NUM_COL(NUM_COL), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .bus(bus), .busy(busy), .row_cnt(row_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected write stream as a queue of words
  typedef struct { logic [7:0] addr; logic [15:0] data; bit last; } word_t;
  word_t       q[$];
  word_t       w;
  logic [7:0]  m_cur = '0;
  logic [15:0] m_cnt = '0;
  bit          m_idle;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_row_cnt", 32'(row_cnt), 32'd0);
      q.delete();
      m_cur = '0;
      m_cnt = '0;
    end else begin
      m_idle = (q.size() == 0);
      chk("m_in_ready", 32'(bus.in_ready), 32'(m_idle && !start));
      chk("m_busy", 32'(busy), 32'(!m_idle));
      chk("m_wr_en", 32'(bus.fifo_wr_en), 32'(!m_idle && !bus.fifo_full));
      chk("m_row_cnt", 32'(row_cnt), 32'(m_cnt));
      if (!m_idle) begin
        chk("m_addr", 32'(bus.fifo_addr), 32'(q[0].addr));
        chk("m_data", 32'(bus.fifo_data), 32'(q[0].data));
        if (!bus.fifo_full) begin
          w = q.pop_front();
          if (w.last) m_cnt = m_cnt + 16'd1;
        end
      end else if (start) begin
        m_cur = base_addr;
        m_cnt = '0;
      end else if (bus.in_valid) begin
        for (int c = 0; c < int'(NUM_COL); c++)
          q.push_back('{addr: 8'(m_cur + 8'(c)), data: bus.in_data[c*16 +: 16],
                        last: (c == int'(NUM_COL) - 1)});
        m_cur = 8'(m_cur + 8'(NUM_COL));
      end
    end
  end

  // Present a row and return one cycle after the accepting edge with in_valid low
  task automatic accept_row(input logic [63:0] row);
    bit got = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = row;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for n writes starting at column first, checking address and data
  task automatic collect(input int first, input int n, input logic [7:0] a0,
                         input logic [63:0] row, input string tag);
    logic [63:0] r;
    r = row;
    for (int c = first; c < first + n; c++) begin
      bit got = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.fifo_wr_en) begin got = 1; break; end
      end
      if (!got) chk({tag, "_wr_timeout"}, 32'd0, 32'd1);
      else begin
        wcyc.push_back(cyc);
        chk({tag, "_addr"}, 32'(bus.fifo_addr), 32'(8'(a0 + 8'(c))));
        chk({tag, "_data"}, 32'(bus.fifo_data), 32'(r[c*16 +: 16]));
      end
    end
  endtask

  typedef struct {
    bit          do_start;
    logic [7:0]  base;
    logic [63:0] row;
    logic [7:0]  exp_addr0;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    vecs[0] = '{1'b1, 8'h10, {16'd4, 16'd3, 16'd2, 16'd1}, 8'h10, 16'd1};
    vecs[1] = '{1'b0, 8'h00, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 8'h14, 16'd2};
    vecs[2] = '{1'b1, 8'hFE, {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 8'hFE, 16'd1};
    vecs[3] = '{1'b0, 8'h55, {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000}, 8'h02, 16'd2};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.fifo_full = 1'b0;
    repeat (3) tick();
    chk("reset_addr", 32'(bus.fifo_addr), 32'd0);
    chk("reset_data", 32'(bus.fifo_data), 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven rows: start/base, expected first address, row count after
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].do_start) begin
        start = 1'b1;
        base_addr = vecs[i].base;
        tick();
        start = 1'b0;
      end
      accept_row(vecs[i].row);
      collect(0, int'(NUM_COL), vecs[i].exp_addr0, vecs[i].row, "tbl");
      @(negedge clk);
      chk("tbl_row_cnt", 32'(row_cnt), 32'(vecs[i].exp_cnt));
      tick();
    end

    // Back-to-back rows with in_valid held: one idle cycle between bursts
    start = 1'b1; base_addr = 8'h20; tick(); start = 1'b0;
    ra = {16'h1004, 16'h1003, 16'h1002, 16'h1001};
    rb = {16'h2004, 16'h2003, 16'h2002, 16'h2001};
    wcyc.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = ra;
    @(negedge clk);
    chk("b2b_ready_a", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_data = rb;
    collect(0, 4, 8'h20, ra, "b2b_a");
    @(negedge clk);
    chk("b2b_idle_ready", 32'(bus.in_ready), 32'd1);
    chk("b2b_idle_wr", 32'(bus.fifo_wr_en), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    collect(0, 4, 8'h24, rb, "b2b_b");
    if (wcyc.size() == 8) begin
      chk("b2b_burst_a", 32'(wcyc[3] - wcyc[0]), 32'd3);
      chk("b2b_gap", 32'(wcyc[4] - wcyc[3]), 32'd2);
      chk("b2b_burst_b", 32'(wcyc[7] - wcyc[4]), 32'd3);
    end else chk("b2b_nwrites", 32'(wcyc.size()), 32'd8);
    tick();

    // Backpressure for 3 cycles after the second write
    start = 1'b1; base_addr = 8'h30; tick(); start = 1'b0;
    ra = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
    accept_row(ra);
    collect(0, 2, 8'h30, ra, "bp");
    tick();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      chk("bp_hold_addr", 32'(bus.fifo_addr), 32'h32);
      chk("bp_hold_data", 32'(bus.fifo_data), 32'h2222);
    end
    tick();
    bus.fifo_full = 1'b0;
    collect(2, 2, 8'h30, ra, "bp");
    @(negedge clk);
    chk("bp_row_cnt", 32'(row_cnt), 32'd1);
    tick();

    // start and in_valid together in IDLE: row deferred to next cycle at base
    ra = {16'h0D04, 16'h0D03, 16'h0D02, 16'h0D01};
    start = 1'b1; base_addr = 8'h40;
    bus.in_valid = 1'b1; bus.in_data = ra;
    @(negedge clk);
    chk("sv_ready_blocked", 32'(bus.in_ready), 32'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("sv_ready_next", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    collect(0, 4, 8'h40, ra, "sv");
    @(negedge clk);
    chk("sv_row_cnt", 32'(row_cnt), 32'd1);
    tick();

    // Reset in the middle of a row
    ra = {16'h5555, 16'h6666, 16'h7777, 16'h8888};
    accept_row(ra);
    collect(0, 1, 8'h44, ra, "rmid");
    tick();
    chk("rmid_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_row_cnt", 32'(row_cnt), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rmid_ready", 32'(bus.in_ready), 32'd1);
      chk("rmid_no_wr", 32'(bus.fifo_wr_en), 32'd0);
    end
    tick();

    // Randomized traffic checked by the model
    for (int k = 0; k < 600; k++) begin
      start         = ($urandom_range(0, 19) == 0);
      base_addr     = 8'($urandom);
      bus.in_valid  = ($urandom_range(0, 9) < 6);
      bus.in_data   = {32'($urandom), 32'($urandom)};
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.fifo_full = 1'b0;
    repeat (12) tick();
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("rand_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
